// File: rtl/snn_pkg.sv
// Shared definitions for the neuron grid datapath: parameter-word layout,
// scan FSM states and saturating arithmetic.
package snn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INTEG,
      S_FIRE,
      S_EMIT,
      S_DONE
   } state_t;

   // Parameter word, LSB first:
   //   CONN[na] | POT | RST_POT | WEIGHTS[nt] | LEAK | POS_TH | NEG_TH | RST_MODE | DEST[pk]
   function automatic int param_w(input int na, input int nt, input int pw, input int pk);
      return na + pw * (nt + 5) + 1 + pk;
   endfunction

   function automatic int off_conn();
      return 0;
   endfunction

   function automatic int off_pot(input int na);
      return na;
   endfunction

   function automatic int off_rst_pot(input int na, input int pw);
      return na + pw;
   endfunction

   function automatic int off_weights(input int na, input int pw);
      return na + 2 * pw;
   endfunction

   function automatic int off_leak(input int na, input int nt, input int pw);
      return na + pw * (nt + 2);
   endfunction

   function automatic int off_pos_th(input int na, input int nt, input int pw);
      return na + pw * (nt + 3);
   endfunction

   function automatic int off_neg_th(input int na, input int nt, input int pw);
      return na + pw * (nt + 4);
   endfunction

   function automatic int off_rst_mode(input int na, input int nt, input int pw);
      return na + pw * (nt + 5);
   endfunction

   function automatic int off_dest(input int na, input int nt, input int pw);
      return na + pw * (nt + 5) + 1;
   endfunction

   // Signed add clamped to the pw-bit two's complement range (never wraps).
   function automatic int sat_add(input int a, input int b, input int pw);
      int s;
      int hi;
      int lo;
      s  = a + b;
      hi = (1 <<< (pw - 1)) - 1;
      lo = -(1 <<< (pw - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/snn_neuron_unit.sv
// Combinational FIRE-stage evaluation: leak, threshold compare, reset/clamp.
module snn_neuron_unit
   import snn_pkg::*;
#(
   parameter int POT_W = 9
) (
   input  logic signed [POT_W-1:0] i_acc,
   input  logic signed [POT_W-1:0] i_leak,
   input  logic signed [POT_W-1:0] i_pos_th,
   input  logic signed [POT_W-1:0] i_neg_th,
   input  logic signed [POT_W-1:0] i_rst_pot,
   input  logic                    i_rst_mode,
   output logic signed [POT_W-1:0] o_pot,
   output logic                    o_fire
);

   logic signed [POT_W-1:0] w_v;
   logic signed [POT_W-1:0] w_sub;

   assign w_v   = POT_W'(sat_add(int'(i_acc), int'(i_leak), POT_W));
   assign w_sub = POT_W'(sat_add(int'(w_v), -int'(i_pos_th), POT_W));

   // Fire on reaching the positive threshold, otherwise floor at the negative threshold
   always_comb begin
      o_fire = 1'b0;
      o_pot  = w_v;
      if (w_v >= i_pos_th) begin
         o_fire = 1'b1;
         o_pot  = i_rst_mode ? w_sub : i_rst_pot;
      end else if (w_v < i_neg_th) begin
         o_pot = i_neg_th;
      end
   end

endmodule

// File: rtl/neuron_grid_datapath_param.sv
// SNN core datapath: per tick, scans every neuron over every axon, integrates
// typed weights, applies leak/threshold/reset, writes the potential back and
// emits a destination packet per spike over a stalling valid/ready handshake.
module neuron_grid_datapath_param
   import snn_pkg::*;
#(
   parameter  int NUM_AXONS   = 256,
   parameter  int NUM_NEURONS = 256,
   parameter  int NUM_TYPES   = 4,
   parameter  int POT_W       = 9,
   parameter  int PKT_W       = 30,
   localparam int NW          = $clog2(NUM_NEURONS),
   localparam int AW          = $clog2(NUM_AXONS),
   localparam int TW          = $clog2(NUM_TYPES),
   localparam int PARAM_W     = param_w(NUM_AXONS, NUM_TYPES, POT_W, PKT_W)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick_start,
   input  logic [NUM_AXONS-1:0] axon_spikes,
   input  logic                 param_wen,
   input  logic [NW-1:0]        param_addr,
   input  logic [PARAM_W-1:0]   param_wdata,
   input  logic                 type_wen,
   input  logic [AW-1:0]        type_addr,
   input  logic [TW-1:0]        type_wdata,
   output logic                 spike_valid,
   input  logic                 spike_ready,
   output logic [PKT_W-1:0]     spike_packet,
   output logic                 busy,
   output logic                 tick_done,
   output logic                 cfg_err
);

   localparam int OFF_POT  = off_pot(NUM_AXONS);
   localparam int OFF_RSTP = off_rst_pot(NUM_AXONS, POT_W);
   localparam int OFF_WGT  = off_weights(NUM_AXONS, POT_W);
   localparam int OFF_LEAK = off_leak(NUM_AXONS, NUM_TYPES, POT_W);
   localparam int OFF_POS  = off_pos_th(NUM_AXONS, NUM_TYPES, POT_W);
   localparam int OFF_NEG  = off_neg_th(NUM_AXONS, NUM_TYPES, POT_W);
   localparam int OFF_MODE = off_rst_mode(NUM_AXONS, NUM_TYPES, POT_W);
   localparam int OFF_DEST = off_dest(NUM_AXONS, NUM_TYPES, POT_W);

   state_t r_state;
   state_t w_next;

   logic [PARAM_W-1:0]   r_param_ram [NUM_NEURONS];
   logic [TW-1:0]        r_type_ram  [NUM_AXONS];
   logic [NUM_AXONS-1:0] r_spk;
   logic [NW-1:0]        r_neuron;
   logic [AW-1:0]        r_axon;
   logic signed [POT_W-1:0] r_acc;
   logic                 r_cfg_err;

   logic [PARAM_W-1:0]   w_word;
   logic [NUM_AXONS-1:0] w_conn;
   logic [NUM_TYPES-1:0][POT_W-1:0] w_weights;
   logic [TW-1:0]        w_type;
   logic signed [POT_W-1:0] w_weight;
   logic signed [POT_W-1:0] w_integ;
   logic signed [POT_W-1:0] w_pot_new;
   logic [PKT_W-1:0]     w_dest;
   logic                 w_fire;
   logic                 w_hit;
   logic                 w_last_axon;
   logic                 w_last_neuron;

   // Single-port RAM: the read address is always the neuron under scan
   assign w_word        = r_param_ram[r_neuron];
   assign w_conn        = w_word[off_conn() +: NUM_AXONS];
   assign w_weights     = w_word[OFF_WGT +: NUM_TYPES * POT_W];
   assign w_dest        = w_word[OFF_DEST +: PKT_W];
   assign w_type        = r_type_ram[r_axon];
   assign w_weight      = w_weights[w_type];
   assign w_hit         = w_conn[r_axon] & r_spk[r_axon];
   assign w_integ       = POT_W'(sat_add(int'(r_acc), int'(w_weight), POT_W));
   assign w_last_axon   = (r_axon == AW'(NUM_AXONS - 1));
   assign w_last_neuron = (r_neuron == NW'(NUM_NEURONS - 1));
   assign cfg_err       = r_cfg_err;

   snn_neuron_unit #(.POT_W(POT_W)) u_unit (
      .i_acc      (r_acc),
      .i_leak     (w_word[OFF_LEAK +: POT_W]),
      .i_pos_th   (w_word[OFF_POS +: POT_W]),
      .i_neg_th   (w_word[OFF_NEG +: POT_W]),
      .i_rst_pot  (w_word[OFF_RSTP +: POT_W]),
      .i_rst_mode (w_word[OFF_MODE]),
      .o_pot      (w_pot_new),
      .o_fire     (w_fire)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // FSM next state; EMIT holds until the packet is accepted
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (tick_start) w_next = S_LOAD;
         S_LOAD:  w_next = S_INTEG;
         S_INTEG: if (w_last_axon) w_next = S_FIRE;
         S_FIRE:  if (w_fire)             w_next = S_EMIT;
                  else if (w_last_neuron) w_next = S_DONE;
                  else                    w_next = S_LOAD;
         S_EMIT:  if (spike_ready) w_next = w_last_neuron ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // FSM outputs; packet is forced to zero whenever it is not valid
   always_comb begin
      spike_valid  = 1'b0;
      spike_packet = '0;
      busy         = (r_state != S_IDLE);
      tick_done    = 1'b0;
      case (r_state)
         S_EMIT: begin
            spike_valid  = 1'b1;
            spike_packet = w_dest;
         end
         S_DONE:  tick_done = 1'b1;
         default: ;
      endcase
   end

   // Scan counters, spike latch, integrator and config-error pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_spk     <= '0;
         r_neuron  <= '0;
         r_axon    <= '0;
         r_acc     <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= (param_wen | type_wen) & (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               r_neuron <= '0;
               r_axon   <= '0;
               if (tick_start) r_spk <= axon_spikes;
            end
            S_LOAD: begin
               r_acc  <= w_word[OFF_POT +: POT_W];
               r_axon <= '0;
            end
            S_INTEG: begin
               if (w_hit)        r_acc  <= w_integ;
               if (!w_last_axon) r_axon <= r_axon + AW'(1);
            end
            S_FIRE: if (!w_fire && !w_last_neuron) r_neuron <= r_neuron + NW'(1);
            S_EMIT: if (spike_ready && !w_last_neuron) r_neuron <= r_neuron + NW'(1);
            default: ;
         endcase
      end
   end

   // RAM writes: potential write-back in FIRE; config writes only while idle
   always_ff @(posedge clk) begin
      if (r_state == S_FIRE)
         r_param_ram[r_neuron][OFF_POT +: POT_W] <= w_pot_new;
      else if (r_state == S_IDLE && param_wen)
         r_param_ram[param_addr] <= param_wdata;
      if (r_state == S_IDLE && type_wen)
         r_type_ram[type_addr] <= type_wdata;
   end

endmodule

// File: tb/tb_neuron_grid_datapath_param.sv
// Scoreboard bench for neuron_grid_datapath_param (4 axons, 2 neurons, 2 types).
module tb_neuron_grid_datapath_param;
   import snn_pkg::*;

   localparam int NA   = 4;
   localparam int NN   = 2;
   localparam int NT   = 2;
   localparam int PW   = 9;
   localparam int PK   = 30;
   localparam int PWID = param_w(NA, NT, PW, PK);
   localparam int OP   = off_pot(NA);
   localparam int ORP  = off_rst_pot(NA, PW);
   localparam int OW   = off_weights(NA, PW);
   localparam int OL   = off_leak(NA, NT, PW);
   localparam int OPT  = off_pos_th(NA, NT, PW);
   localparam int ONT  = off_neg_th(NA, NT, PW);
   localparam int OM   = off_rst_mode(NA, NT, PW);
   localparam int OD   = off_dest(NA, NT, PW);

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            tick_start = 1'b0;
   logic [NA-1:0]   axon_spikes = '0;
   logic            param_wen = 1'b0;
   logic [0:0]      param_addr = '0;
   logic [PWID-1:0] param_wdata = '0;
   logic            type_wen = 1'b0;
   logic [1:0]      type_addr = '0;
   logic [0:0]      type_wdata = '0;
   logic            spike_valid;
   logic            spike_ready = 1'b1;
   logic [PK-1:0]   spike_packet;
   logic            busy;
   logic            tick_done;
   logic            cfg_err;

   always #5 clk = ~clk;

   neuron_grid_datapath_param #(
      .NUM_AXONS(NA), .NUM_NEURONS(NN), .NUM_TYPES(NT), .POT_W(PW), .PKT_W(PK)
   ) dut (
      .clk(clk), .reset_n(reset_n), .tick_start(tick_start), .axon_spikes(axon_spikes),
      .param_wen(param_wen), .param_addr(param_addr), .param_wdata(param_wdata),
      .type_wen(type_wen), .type_addr(type_addr), .type_wdata(type_wdata),
      .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_packet(spike_packet),
      .busy(busy), .tick_done(tick_done), .cfg_err(cfg_err)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [PK-1:0] exp_q[$];

   // Bench-side model of the neuron configuration
   int m_conn [NN];
   int m_pot  [NN];
   int m_rst  [NN];
   int m_w    [NN][NT];
   int m_leak [NN];
   int m_pos  [NN];
   int m_neg  [NN];
   bit m_mode [NN];
   int m_dest [NN];
   int m_type [NA];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   function automatic int sat9(input int v);
      if (v > 255)  return 255;
      if (v < -256) return -256;
      return v;
   endfunction

   function automatic logic [PWID-1:0] pack(input int n);
      logic [PWID-1:0] w;
      w = '0;
      w[0 +: NA]   = NA'(m_conn[n]);
      w[OP +: PW]  = PW'(m_pot[n]);
      w[ORP +: PW] = PW'(m_rst[n]);
      for (int t = 0; t < NT; t++) w[OW + t*PW +: PW] = PW'(m_w[n][t]);
      w[OL +: PW]  = PW'(m_leak[n]);
      w[OPT +: PW] = PW'(m_pos[n]);
      w[ONT +: PW] = PW'(m_neg[n]);
      w[OM]        = m_mode[n];
      w[OD +: PK]  = PK'(m_dest[n]);
      return w;
   endfunction

   function automatic int dut_pot(input int n);
      logic [PWID-1:0]        w;
      logic signed [PW-1:0] p;
      w = dut.r_param_ram[n];
      p = w[OP +: PW];
      return int'(p);
   endfunction

   task automatic set_neuron(input int n, input int conn, input int w0, input int w1,
                             input int leak, input int pos, input int neg, input int rst,
                             input bit mode, input int pot);
      m_conn[n] = conn; m_w[n][0] = w0; m_w[n][1] = w1; m_leak[n] = leak;
      m_pos[n] = pos; m_neg[n] = neg; m_rst[n] = rst; m_mode[n] = mode; m_pot[n] = pot;
   endtask

   // Optionally writes axon type ta in the same cycle as the neuron word
   task automatic write_neuron(input int n, input int ta);
      @(posedge clk); #1;
      param_wen = 1'b1; param_addr = 1'(n); param_wdata = pack(n);
      if (ta >= 0) begin
         type_wen = 1'b1; type_addr = 2'(ta); type_wdata = 1'(m_type[ta]);
      end
      @(posedge clk); #1;
      param_wen = 1'b0; type_wen = 1'b0;
   endtask

   task automatic write_type(input int a);
      @(posedge clk); #1;
      type_wen = 1'b1; type_addr = 2'(a); type_wdata = 1'(m_type[a]);
      @(posedge clk); #1;
      type_wen = 1'b0;
   endtask

   task automatic model_neuron(input int n, input logic [NA-1:0] spk, output bit f);
      int acc;
      int v;
      acc = m_pot[n];
      for (int a = 0; a < NA; a++)
         if (m_conn[n][a] && spk[a]) acc = sat9(acc + m_w[n][m_type[a]]);
      v = sat9(acc + m_leak[n]);
      f = 1'b0;
      if (v >= m_pos[n]) begin
         f = 1'b1;
         v = m_mode[n] ? sat9(v - m_pos[n]) : m_rst[n];
      end else if (v < m_neg[n]) begin
         v = m_neg[n];
      end
      m_pot[n] = v;
   endtask

   // Runs one tick; stall = cycles spike_ready is held low on the first spike,
   // poke = config write and stray tick_start mid-scan
   task automatic do_tick(input string name, input logic [NA-1:0] spk, input int stall, input bit poke);
      bit f;
      int fires, cyc, busy_c, done_c, stall_c;
      fires = 0; cyc = 0; busy_c = 0; done_c = 0; stall_c = 0;
      for (int n = 0; n < NN; n++) begin
         model_neuron(n, spk, f);
         if (f) begin
            fires++;
            exp_q.push_back(PK'(m_dest[n]));
         end
      end
      if (stall > 0) spike_ready = 1'b0;
      @(posedge clk); #1;
      tick_start = 1'b1; axon_spikes = spk;
      @(posedge clk); #1;
      tick_start = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (busy) busy_c++;
         if (tick_done) done_c++;
         if (spike_valid && !spike_ready) stall_c++;
         if (poke && cyc == 4) chk({name, "_cfg_err_pulse"}, cfg_err, 1);
         if (poke && cyc == 5) chk({name, "_cfg_err_clear"}, cfg_err, 0);
         if (!busy || cyc >= 1000) break;
         @(posedge clk); #1;
         if (stall > 0 && stall_c == stall) spike_ready = 1'b1;
         if (poke && cyc == 2) begin
            param_wen = 1'b1; param_addr = 1'b0; param_wdata = '1;
            tick_start = 1'b1; axon_spikes = ~spk;
         end
         if (poke && cyc == 3) begin
            param_wen = 1'b0; tick_start = 1'b0;
         end
      end
      spike_ready = 1'b1;
      chk({name, "_ended"}, busy, 0);
      chk({name, "_busy_cycles"}, busy_c, NN * (NA + 2) + 1 + fires + stall);
      chk({name, "_tick_done_cnt"}, done_c, 1);
      chk({name, "_q_empty"}, exp_q.size(), 0);
      for (int n = 0; n < NN; n++)
         chk($sformatf("%s_pot%0d", name, n), dut_pot(n), m_pot[n]);
      exp_q.delete();
   endtask

   // Scoreboard monitor plus hold-while-stalled and zero-when-idle checks
   bit            mon_stalled = 1'b0;
   logic [PK-1:0] mon_prev_pkt = '0;
   always @(negedge clk) begin
      if (!reset_n) begin
         mon_stalled = 1'b0;
      end else begin
         if (mon_stalled) begin
            chk("hold_valid", spike_valid, 1);
            chk("hold_pkt", spike_packet, mon_prev_pkt);
         end
         if (!spike_valid) chk("pkt_zero_idle", spike_packet, 0);
         if (spike_valid && spike_ready) begin
            if (exp_q.size() == 0) chk("extra_spike", spike_valid, 0);
            else                   chk("pkt", spike_packet, exp_q.pop_front());
         end
         mon_stalled  = spike_valid && !spike_ready;
         mon_prev_pkt = spike_packet;
      end
   end

   initial begin
      logic [PWID-1:0] w_before;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", spike_valid, 0);
      chk("rst_pkt", spike_packet, 0);
      chk("rst_done", tick_done, 0);
      chk("rst_cfg_err", cfg_err, 0);

      m_dest[0] = 30'h1234567;
      m_dest[1] = 30'h2ABCDEF;
      for (int a = 0; a < NA; a++) m_type[a] = 0;
      set_neuron(0, 4'b1111, 3, 0, 0, 10, -100, 0, 1'b0, 0);
      set_neuron(1, 4'b0000, 0, 0, 0, 10, -100, 0, 1'b0, 0);
      write_neuron(0, 0);   // both strobes in the same idle cycle
      for (int a = 1; a < NA; a++) write_type(a);
      write_neuron(1, -1);

      // T1: 4 x +3 -> 12 >= 10, fires, reset to 0
      do_tick("t1", 4'b1111, 0, 1'b0);

      // T2: subtractive reset -> 2, then leak +1 with no spikes -> 3
      m_mode[0] = 1'b1;
      write_neuron(0, -1);
      do_tick("t2a", 4'b1111, 0, 1'b0);
      m_leak[0] = 1;
      write_neuron(0, -1);
      do_tick("t2b", 4'b0000, 0, 1'b0);

      // T3: positive saturation fires; negative saturation clamps to neg_th
      set_neuron(0, 4'b1111, 200, 0, 0, 255, -100, 0, 1'b0, 0);
      write_neuron(0, -1);
      do_tick("t3a", 4'b1111, 0, 1'b0);
      set_neuron(0, 4'b1111, -200, 0, 0, 255, -50, 0, 1'b0, 0);
      write_neuron(0, -1);
      do_tick("t3b", 4'b1111, 0, 1'b0);

      // T4: both neurons fire through two axon types, first packet stalled 5 cycles
      m_type[2] = 1; m_type[3] = 1;
      write_type(2);
      write_type(3);
      set_neuron(0, 4'b1111, 3, 3, 0, 10, -100, 0, 1'b0, 0);
      set_neuron(1, 4'b1111, 2, 4, 0, 10, -100, 0, 1'b0, 0);
      write_neuron(0, -1);
      write_neuron(1, -1);
      do_tick("t4", 4'b1111, 5, 1'b0);

      // T5: config write and tick_start mid-scan are dropped
      set_neuron(0, 4'b0011, 3, 3, 0, 10, -100, 0, 1'b0, 0);
      write_neuron(0, -1);
      do_tick("t5", 4'b0111, 0, 1'b1);
      w_before = pack(0);
      chk("t5_ram_word", dut.r_param_ram[0], w_before);

      // T6: reset during EMIT drops the spike, keeps the written-back potential
      set_neuron(0, 4'b1111, 3, 3, 0, 10, -100, 0, 1'b1, 1);
      write_neuron(0, -1);
      begin
         bit f;
         model_neuron(0, 4'b1111, f);
      end
      spike_ready = 1'b0;
      @(posedge clk); #1;
      tick_start = 1'b1; axon_spikes = 4'b1111;
      @(posedge clk); #1;
      tick_start = 1'b0;
      for (int i = 0; i < 100 && !spike_valid; i++) @(negedge clk);
      chk("t6_valid", spike_valid, 1);
      chk("t6_pkt", spike_packet, PK'(m_dest[0]));
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", spike_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_pkt", spike_packet, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      spike_ready = 1'b1;
      chk("t6_pot_kept", dut_pot(0), m_pot[0]);
      do_tick("t6_rerun", 4'b1111, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
